// File: rtl/br_update_queue_pkg.sv
// FetchUnitTypes: types shared by the fetch unit and the branch update path.
// Holds the BrUpdateEntry record that a resolved branch carries to the PAp
// pattern-history table, and the default depth of the branch update queue.
// The package has no ports.
package FetchUnitTypes;

  localparam int PHT_PAP_BITS              = 8;
  localparam int PAP_PHT_ENTRY_BITS        = 2;
  localparam int BR_HISTORY_BITS           = 4;
  localparam int BR_UPDATE_QUEUE_ENTRY_NUM = 8;

  typedef logic [PHT_PAP_BITS-1:0]       PAP_PHT_IndexPath;
  typedef logic [PAP_PHT_ENTRY_BITS-1:0] PAP_PHT_ENTRY;

  typedef struct packed {
    PAP_PHT_IndexPath             index;
    PAP_PHT_ENTRY                 prev_counter;
    logic [BR_HISTORY_BITS-1:0]   history;
    logic                         exec_taken;
    logic                         is_cond_br;
    logic                         mispred;
  } BrUpdateEntry;

  localparam int BR_UPDATE_ENTRY_BITS = $bits(BrUpdateEntry);

endpackage

// File: rtl/br_update_queue_select.sv
// br_update_select: combinational drain-candidate conflict check.
// Walks the candidates in order from the queue head and issues each one only
// while every earlier candidate issued and its PHT bank and index differ from
// all issued ones, so the issue mask is always a contiguous run from lane 0.
// Ports:
//   cand_valid  in  OUT_WIDTH             candidate k is present
//   cand_index  in  OUT_WIDTH*INDEX_BITS  PHT index of each candidate
//   issue       out OUT_WIDTH             candidates that drain this cycle
//   issue_count out clog2(OUT_WIDTH+1)    number of issued candidates
module br_update_select #(
  parameter int OUT_WIDTH  = 2,
  parameter int INDEX_BITS = 8,
  parameter int BANK_BITS  = 1
) (
  input  logic [OUT_WIDTH-1:0]            cand_valid,
  input  logic [OUT_WIDTH*INDEX_BITS-1:0] cand_index,
  output logic [OUT_WIDTH-1:0]            issue,
  output logic [$clog2(OUT_WIDTH+1)-1:0]  issue_count
);

  localparam int ISSUE_BITS = $clog2(OUT_WIDTH+1);

  logic                  chain;
  logic                  ok;
  logic [INDEX_BITS-1:0] idx_k;
  logic [INDEX_BITS-1:0] idx_j;

  // Because issue is strictly in order, every j < k has issued whenever the
  // chain is still alive, so comparing against all earlier lanes suffices.
  always_comb begin
    issue       = '0;
    issue_count = '0;
    chain       = 1'b1;
    ok          = 1'b0;
    idx_k       = '0;
    idx_j       = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      ok    = chain & cand_valid[k];
      idx_k = cand_index[k*INDEX_BITS +: INDEX_BITS];
      for (int j = 0; j < k; j++) begin
        idx_j = cand_index[j*INDEX_BITS +: INDEX_BITS];
        if ((idx_k[BANK_BITS-1:0] == idx_j[BANK_BITS-1:0]) || (idx_k == idx_j)) begin
          ok = 1'b0;
        end
      end
      issue[k] = ok;
      chain    = ok;
      if (ok) begin
        issue_count = issue_count + ISSUE_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/br_update_queue.sv
// br_update_queue: buffers resolved branch results from the integer issue
// lanes and drains them into the multi-bank PAp PHT write ports. Entries that
// would collide on a bank or index are deferred to a later cycle, never
// dropped, so updates to one PHT index stay in order.
// Optional feature: define BR_UPDATE_QUEUE_BYPASS_EN to let valid inputs
// drain in the same cycle while the queue is empty; otherwise every entry is
// stored first and outputs depend on registered state only.
// Ports:
//   clk, rst   in  clock, asynchronous active-high reset
//   in_valid   in  IN_WIDTH               per-lane resolved-branch strobe
//   in_entry   in  IN_WIDTH*entry bits    lane payloads (lane 0 in low bits)
//   in_ready   out 1                      room for a full set of lanes
//   out_valid  out OUT_WIDTH              per-lane PHT write strobe
//   out_entry  out OUT_WIDTH*entry bits   PHT write payloads (zero when idle)
//   count      out clog2(ENTRY_NUM+1)     occupancy
//   overflow   out 1                      sticky: input arrived while not ready
module br_update_queue
  import FetchUnitTypes::*;
#(
  parameter int ENTRY_NUM  = BR_UPDATE_QUEUE_ENTRY_NUM,
  parameter int IN_WIDTH   = 2,
  parameter int OUT_WIDTH  = 2,
  parameter int INDEX_BITS = PHT_PAP_BITS,
  parameter int BANK_BITS  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [IN_WIDTH-1:0]                   in_valid,
  input  logic [IN_WIDTH*BR_UPDATE_ENTRY_BITS-1:0]  in_entry,
  output logic                                  in_ready,
  output logic [OUT_WIDTH-1:0]                  out_valid,
  output logic [OUT_WIDTH*BR_UPDATE_ENTRY_BITS-1:0] out_entry,
  output logic [$clog2(ENTRY_NUM+1)-1:0]        count,
  output logic                                  overflow
);

  localparam int PTR_BITS   = $clog2(ENTRY_NUM);
  localparam int CNT_BITS   = $clog2(ENTRY_NUM+1);
  localparam int ISSUE_BITS = $clog2(OUT_WIDTH+1);
  localparam int EB         = BR_UPDATE_ENTRY_BITS;
  localparam logic [CNT_BITS-1:0] READY_LIMIT = CNT_BITS'(ENTRY_NUM - IN_WIDTH);

  BrUpdateEntry                  storage [ENTRY_NUM];
  logic [PTR_BITS-1:0]           head;
  logic [PTR_BITS-1:0]           tail;
  logic [CNT_BITS-1:0]           lane_slot [IN_WIDTH];
  logic [PTR_BITS-1:0]           lane_offset [IN_WIDTH];
  logic [IN_WIDTH-1:0]           lane_write;
  logic [CNT_BITS-1:0]           valid_count;
  logic [CNT_BITS-1:0]           enq_num;
  logic [CNT_BITS-1:0]           deq_num;
  logic                          do_enq;
  BrUpdateEntry                  cand [OUT_WIDTH];
  logic [OUT_WIDTH-1:0]          cand_valid;
  logic [OUT_WIDTH*INDEX_BITS-1:0] cand_index;
  logic [OUT_WIDTH-1:0]          issue;
  logic [ISSUE_BITS-1:0]         issue_count;

  // Ready looks only at the registered count, so a same-cycle drain does not
  // open up room until the next cycle.
  assign in_ready = (count <= READY_LIMIT);
  assign do_enq   = in_ready & (|in_valid);

  // Compaction: each valid lane's position among the valid lanes, lane 0 first.
  always_comb begin
    valid_count = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      lane_slot[i] = valid_count;
      if (in_valid[i]) begin
        valid_count = valid_count + CNT_BITS'(1);
      end
    end
  end

`ifdef BR_UPDATE_QUEUE_BYPASS_EN
  logic                bypass_active;
  logic [CNT_BITS-1:0] bypass_skip;
  BrUpdateEntry        comp [OUT_WIDTH];

  assign bypass_active = (count == '0);
  assign bypass_skip   = bypass_active ? CNT_BITS'(issue_count) : '0;
  assign deq_num       = bypass_active ? '0 : CNT_BITS'(issue_count);

  // Compacted inputs presented as candidates while the queue is empty.
  always_comb begin
    for (int s = 0; s < OUT_WIDTH; s++) begin
      comp[s] = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (in_valid[i] && (lane_slot[i] == CNT_BITS'(s))) begin
          comp[s] = in_entry[i*EB +: EB];
        end
      end
    end
  end

  // Inputs that issued straight out are not stored; the rest close up behind tail.
  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      lane_write[i]  = do_enq & in_valid[i] & (lane_slot[i] >= bypass_skip);
      lane_offset[i] = PTR_BITS'(lane_slot[i] - bypass_skip);
    end
  end

  assign enq_num = do_enq ? (valid_count - bypass_skip) : '0;
`else
  assign deq_num = CNT_BITS'(issue_count);

  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      lane_write[i]  = do_enq & in_valid[i];
      lane_offset[i] = PTR_BITS'(lane_slot[i]);
    end
  end

  assign enq_num = do_enq ? valid_count : '0;
`endif

  // Candidate k is the entry at head+k; the pointer sum wraps naturally.
  always_comb begin
    cand_index = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      cand[k]       = storage[head + PTR_BITS'(k)];
      cand_valid[k] = (CNT_BITS'(k) < count);
`ifdef BR_UPDATE_QUEUE_BYPASS_EN
      if (bypass_active) begin
        cand[k]       = comp[k];
        cand_valid[k] = (CNT_BITS'(k) < valid_count);
      end
`endif
      cand_index[k*INDEX_BITS +: INDEX_BITS] = INDEX_BITS'(cand[k].index);
    end
  end

  br_update_select #(
    .OUT_WIDTH  (OUT_WIDTH),
    .INDEX_BITS (INDEX_BITS),
    .BANK_BITS  (BANK_BITS)
  ) u_select (
    .cand_valid  (cand_valid),
    .cand_index  (cand_index),
    .issue       (issue),
    .issue_count (issue_count)
  );

  // Payload is zeroed on idle lanes so a reset queue shows all-zero outputs.
  always_comb begin
    out_valid = issue;
    out_entry = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      if (issue[k]) begin
        out_entry[k*EB +: EB] = cand[k];
      end
    end
  end

  // Entry storage is deliberately not reset; head/tail/count define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (lane_write[i]) begin
        storage[tail + lane_offset[i]] <= in_entry[i*EB +: EB];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      head  <= head + PTR_BITS'(deq_num);
      tail  <= tail + PTR_BITS'(enq_num);
      count <= count + enq_num - deq_num;
      if ((|in_valid) && !in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_br_update_queue.sv
// Testbench for br_update_queue (default build, bypass disabled).
// Expected entries go into a scoreboard queue as they are driven; each cycle
// the expected drain mask is derived from the scoreboard head and matching
// entries are popped and compared against the DUT outputs.
module tb_br_update_queue;
  import FetchUnitTypes::*;

  localparam int EB = BR_UPDATE_ENTRY_BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    in_valid;
  logic [2*EB-1:0] in_entry;
  logic          in_ready;
  logic [1:0]    out_valid;
  logic [2*EB-1:0] out_entry;
  logic [3:0]    count;
  logic          overflow;

  br_update_queue #(
    .ENTRY_NUM  (8),
    .IN_WIDTH   (2),
    .OUT_WIDTH  (2),
    .INDEX_BITS (PHT_PAP_BITS),
    .BANK_BITS  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_entry  (in_entry),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_entry (out_entry),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  BrUpdateEntry exp_q [$];
  logic         exp_ovf;
  logic         ready_now;
  logic [3:0]   hist_seq;
  logic [1:0]   last_valid;
  logic [7:0]   last_idx0;
  logic [3:0]   last_count;
  logic         last_ready;
  int           n_dual;

  function automatic BrUpdateEntry mk(input logic [7:0] idx, input logic [3:0] hist);
    BrUpdateEntry e;
    e.index        = idx;
    e.prev_counter = idx[2:1];
    e.history      = hist;
    e.exec_taken   = idx[0] ^ hist[0];
    e.is_cond_br   = ~hist[1];
    e.mispred      = hist[2];
    return e;
  endfunction

  task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Called at a falling edge: outputs shown now drain at the next rising edge.
  task automatic checkOutput();
    int           sz;
    logic [1:0]   emask;
    BrUpdateEntry a0;
    BrUpdateEntry a1;
    BrUpdateEntry obs_e;
    sz        = exp_q.size();
    ready_now = ((8 - sz) >= 2);
    compareValue("count", 32'(count), 32'(sz));
    compareValue("in_ready", 32'(in_ready), 32'(ready_now));
    compareValue("overflow", 32'(overflow), 32'(exp_ovf));
    emask = 2'b00;
    if (sz >= 1) emask[0] = 1'b1;
    if (sz >= 2) begin
      a0 = exp_q[0];
      a1 = exp_q[1];
      if ((a0.index[0] != a1.index[0]) && (a0.index != a1.index)) emask[1] = 1'b1;
    end
    compareValue("out_valid", 32'(out_valid), 32'(emask));
    for (int k = 0; k < 2; k++) begin
      if (emask[k]) begin
        obs_e = out_entry[k*EB +: EB];
        compareValue("out_entry", 32'(obs_e), 32'(exp_q[k]));
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (emask[k]) void'(exp_q.pop_front());
    end
    obs_e      = out_entry[EB-1:0];
    last_valid = out_valid;
    last_idx0  = obs_e.index;
    last_count = count;
    last_ready = in_ready;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [7:0] i0, input logic [7:0] i1);
    BrUpdateEntry e0;
    BrUpdateEntry e1;
    e0       = mk(i0, hist_seq);
    hist_seq = hist_seq + 4'd1;
    e1       = mk(i1, hist_seq);
    hist_seq = hist_seq + 4'd1;
    in_valid = v;
    in_entry = {e1, e0};
    if (v != 2'b00) begin
      if (ready_now) begin
        if (v[0]) exp_q.push_back(e0);
        if (v[1]) exp_q.push_back(e1);
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic [1:0] v, input logic [7:0] i0, input logic [7:0] i1);
    @(negedge clk);
    checkOutput();
    applyStimulus(v, i0, i1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 2'b00;
    in_entry   = '0;
    exp_ovf    = 1'b0;
    ready_now  = 1'b1;
    hist_seq   = 4'd0;
    last_valid = 2'b00;
    last_idx0  = 8'h00;
    last_count = 4'd0;
    last_ready = 1'b0;
    n_dual     = 0;

    // Reset state
    repeat (2) @(negedge clk);
    compareValue("reset_count", 32'(count), 32'd0);
    compareValue("reset_out_valid", 32'(out_valid), 32'd0);
    compareValue("reset_overflow", 32'(overflow), 32'd0);
    compareValue("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Single entry: visible one cycle after enqueue, then drained
    cycle(2'b01, 8'h05, 8'h77);
    cycle(2'b00, 8'h00, 8'h00);
    compareValue("single_valid", 32'(last_valid), 32'b01);
    compareValue("single_index", 32'(last_idx0), 32'h05);
    cycle(2'b00, 8'h00, 8'h00);
    compareValue("single_empty", 32'(last_count), 32'd0);

    // Bank conflict: 0x04 and 0x06 share bank 0
    cycle(2'b11, 8'h04, 8'h06);
    cycle(2'b00, 8'h00, 8'h00);
    compareValue("bank_first_valid", 32'(last_valid), 32'b01);
    compareValue("bank_first_index", 32'(last_idx0), 32'h04);
    cycle(2'b00, 8'h00, 8'h00);
    compareValue("bank_second_valid", 32'(last_valid), 32'b01);
    compareValue("bank_second_index", 32'(last_idx0), 32'h06);

    // Same index twice: one per cycle, enqueue order kept by the scoreboard
    cycle(2'b11, 8'h09, 8'h09);
    cycle(2'b00, 8'h00, 8'h00);
    compareValue("same_first_valid", 32'(last_valid), 32'b01);
    cycle(2'b00, 8'h00, 8'h00);
    compareValue("same_second_valid", 32'(last_valid), 32'b01);
    compareValue("same_second_index", 32'(last_idx0), 32'h09);

    // Fill: all bank 0, net +1 per cycle until count reaches 7
    for (int n = 0; n < 6; n++) begin
      cycle(2'b11, 8'(8'h20 + 4*n), 8'(8'h22 + 4*n));
    end
    cycle(2'b11, 8'h80, 8'h82);
    compareValue("full_count", 32'(last_count), 32'd7);
    compareValue("full_in_ready", 32'(last_ready), 32'd0);
    cycle(2'b00, 8'h00, 8'h00);
    compareValue("full_overflow", 32'(overflow), 32'd1);
    compareValue("full_no_enqueue", 32'(last_count), 32'd6);

    // Asynchronous reset with five entries queued
    @(negedge clk);
    compareValue("pre_reset_count", 32'(count), 32'd5);
    #2 rst = 1'b1;
    #1;
    compareValue("async_reset_count", 32'(count), 32'd0);
    compareValue("async_reset_out_valid", 32'(out_valid), 32'd0);
    compareValue("async_reset_overflow", 32'(overflow), 32'd0);
    compareValue("async_reset_out_entry", 32'(out_entry), 32'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    cycle(2'b00, 8'h00, 8'h00);
    compareValue("post_reset_empty", 32'(last_count), 32'd0);

    // Wraparound: 20 entries, alternating banks, two drained per cycle
    for (int n = 0; n < 10; n++) begin
      cycle(2'b11, 8'(8'h40 + 2*n), 8'(8'h41 + 2*n));
      if (last_valid == 2'b11) n_dual++;
    end
    for (int n = 0; n < 2; n++) begin
      cycle(2'b00, 8'h00, 8'h00);
      if (last_valid == 2'b11) n_dual++;
    end
    compareValue("wrap_dual_drains", 32'(n_dual), 32'd10);
    @(negedge clk);
    compareValue("wrap_final_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
